// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the 16-bit datapath: fetch, decode, execute, memory, writeback.
// Outputs are registered and decoded from the next state, so each one is glitch-free for its whole state.
module multicycle_controller #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH/4-1:0] opCode,
    input  logic [WIDTH/4-1:0] opCodeExt,
    input  logic               condTrue,
    output logic               instrRegEn,
    output logic               regFileEn,
    output logic               memDataRegEn,
    output logic               muxMemAdr,
    output logic               outRegEn,
    output logic               codesComputed,
    output logic               muxBin,
    output logic               muxPc,
    output logic               shiftOp,
    output logic [1:0]         muxExtImm,
    output logic [1:0]         muxAin,
    output logic [1:0]         muxToRegFile,
    output logic [1:0]         muxShiftAmount,
    output logic [1:0]         muxShiftShifter,
    output logic [1:0]         muxOut,
    output logic [1:0]         pcEn,
    output logic [4:0]         aluOp,
    output logic               memWrite,
    output logic [3:0]         state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  LATCH  = 4'd1,  DECODE = 4'd2,  ALU_EX = 4'd3,
        WB     = 4'd4,  LD_ADR = 4'd5,  LD_CAP = 4'd6,  LD_WB  = 4'd7,
        ST     = 4'd8,  J_CHK  = 4'd9,  J_EX   = 4'd10, J_TAKE = 4'd11,
        LINK   = 4'd12, B_CHK  = 4'd13, B_EX   = 4'd14
    } state_e;

    typedef enum logic [3:0] {
        K_NOP, K_ALU_R, K_ALU_I, K_SHIFT, K_LUI,
        K_LOAD, K_STOR, K_JCOND, K_JAL, K_BCOND
    } kind_e;

    localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_AND = 5'd2, ALU_OR = 5'd3,
                           ALU_XOR = 5'd4, ALU_CMP = 5'd5, ALU_MOV = 5'd6;

    typedef struct packed {
        logic       instrRegEn;
        logic       regFileEn;
        logic       memDataRegEn;
        logic       muxMemAdr;
        logic       outRegEn;
        logic       codesComputed;
        logic       muxBin;
        logic       muxPc;
        logic       shiftOp;
        logic       memWrite;
        logic [1:0] muxExtImm;
        logic [1:0] muxAin;
        logic [1:0] muxToRegFile;
        logic [1:0] muxShiftAmount;
        logic [1:0] muxShiftShifter;
        logic [1:0] muxOut;
        logic [1:0] pcEn;
        logic [4:0] aluOp;
    } ctrl_t;

    // R-type ext codes and immediate opcodes share one ALU code space
    function automatic logic is_alu(input logic [3:0] c);
        case (c)
            4'b0101, 4'b1001, 4'b1011, 4'b0001, 4'b0010, 4'b0011, 4'b1101: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [4:0] alu_of(input logic [3:0] c);
        case (c)
            4'b1001: return ALU_SUB;
            4'b1011: return ALU_CMP;
            4'b0001: return ALU_AND;
            4'b0010: return ALU_OR;
            4'b0011: return ALU_XOR;
            4'b1101: return ALU_MOV;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic kind_e kind_of(input logic [3:0] op, input logic [3:0] ext);
        kind_e k;
        k = K_NOP;
        case (op)
            4'b0000: k = is_alu(ext) ? K_ALU_R : K_NOP;
            4'b1000: k = (ext[3:2] == 2'b00 || ext == 4'b0100 || ext == 4'b0110) ? K_SHIFT : K_NOP;
            4'b1111: k = K_LUI;
            4'b1100: k = K_BCOND;
            4'b0100: begin
                case (ext)
                    4'b0000: k = K_LOAD;
                    4'b0100: k = K_STOR;
                    4'b1100: k = K_JCOND;
                    4'b1000: k = K_JAL;
                    default: k = K_NOP;
                endcase
            end
            default: k = is_alu(op) ? K_ALU_I : K_NOP;
        endcase
        return k;
    endfunction

    function automatic ctrl_t ctrl_of(input state_e s, input logic [3:0] op, input logic [3:0] ext);
        ctrl_t      c;
        kind_e      k;
        logic [3:0] code;
        c    = '0;
        k    = kind_of(op, ext);
        code = (k == K_ALU_R) ? ext : op;
        case (s)
            LATCH:  c.instrRegEn = 1'b1;
            DECODE: c.pcEn = 2'b11;
            ALU_EX: begin
                c.muxAin   = 2'b01;
                c.outRegEn = 1'b1;
                case (k)
                    K_ALU_R, K_ALU_I: begin
                        c.aluOp         = alu_of(code);
                        c.muxOut        = 2'b01;
                        c.muxBin        = (k == K_ALU_I);
                        c.codesComputed = (code == 4'b0101 || code == 4'b1001 || code == 4'b1011);
                        if (k == K_ALU_I && (code == 4'b0001 || code == 4'b0010 || code == 4'b0011))
                            c.muxExtImm = 2'b10;
                    end
                    K_SHIFT: begin
                        // ext bit 1 separates arithmetic from logical in both register and immediate forms
                        c.shiftOp = ext[1];
                        if (ext[3:2] == 2'b00) begin
                            c.muxShiftAmount = 2'b01;
                            c.muxExtImm      = 2'b01;
                        end
                    end
                    K_LUI: begin
                        c.muxExtImm       = 2'b10;
                        c.muxShiftShifter = 2'b01;
                        c.muxShiftAmount  = 2'b10;
                    end
                    default: ;
                endcase
            end
            WB: begin
                c.muxToRegFile = 2'b01;
                c.regFileEn    = 1'b1;
            end
            LD_ADR: c.muxMemAdr = 1'b1;
            LD_CAP: begin
                c.muxMemAdr    = 1'b1;
                c.memDataRegEn = 1'b1;
            end
            LD_WB: c.regFileEn = 1'b1;
            ST: begin
                c.muxMemAdr = 1'b1;
                c.memWrite  = 1'b1;
            end
            J_EX: begin
                c.muxAin   = 2'b11;
                c.muxOut   = 2'b01;
                c.outRegEn = 1'b1;
            end
            J_TAKE: begin
                c.pcEn  = 2'b10;
                c.muxPc = 1'b1;
            end
            LINK: begin
                c.muxToRegFile = 2'b10;
                c.regFileEn    = 1'b1;
            end
            B_EX: begin
                c.muxBin   = 1'b1;
                c.muxOut   = 2'b01;
                c.outRegEn = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    state_e     state_q, state_d;
    logic [3:0] op_q, op_d, ext_q, ext_d;
    ctrl_t      ctrl_q, ctrl_d;
    kind_e      kind_q;

    always_comb begin
        op_d  = op_q;
        ext_d = ext_q;
        if (state_q == DECODE) begin
            op_d  = opCode;
            ext_d = opCodeExt;
        end
    end

    assign kind_q = kind_of(op_q, ext_q);

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = LATCH;
            LATCH:  state_d = DECODE;
            DECODE: begin
                case (kind_of(opCode, opCodeExt))
                    K_ALU_R, K_ALU_I, K_SHIFT, K_LUI: state_d = ALU_EX;
                    K_LOAD:           state_d = LD_ADR;
                    K_STOR:           state_d = ST;
                    K_JCOND, K_JAL:   state_d = J_CHK;
                    K_BCOND:          state_d = B_CHK;
                    default:          state_d = FETCH;
                endcase
            end
            ALU_EX: begin
                if ((kind_q == K_ALU_R && ext_q == 4'b1011) || (kind_q == K_ALU_I && op_q == 4'b1011))
                    state_d = FETCH;
                else
                    state_d = WB;
            end
            LD_ADR: state_d = LD_CAP;
            LD_CAP: state_d = LD_WB;
            // JAL is unconditional; the condition field holds its destination register
            J_CHK:  state_d = (kind_q == K_JAL || condTrue) ? J_EX : FETCH;
            J_EX:   state_d = (kind_q == K_JAL) ? LINK : J_TAKE;
            LINK:   state_d = J_TAKE;
            B_CHK:  state_d = condTrue ? B_EX : FETCH;
            B_EX:   state_d = J_TAKE;
            default: state_d = FETCH;
        endcase
    end

    assign ctrl_d = ctrl_of(state_d, op_d, ext_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            op_q    <= '0;
            ext_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ext_q   <= ext_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign instrRegEn      = ctrl_q.instrRegEn;
    assign regFileEn       = ctrl_q.regFileEn;
    assign memDataRegEn    = ctrl_q.memDataRegEn;
    assign muxMemAdr       = ctrl_q.muxMemAdr;
    assign outRegEn        = ctrl_q.outRegEn;
    assign codesComputed   = ctrl_q.codesComputed;
    assign muxBin          = ctrl_q.muxBin;
    assign muxPc           = ctrl_q.muxPc;
    assign shiftOp         = ctrl_q.shiftOp;
    assign memWrite        = ctrl_q.memWrite;
    assign muxExtImm       = ctrl_q.muxExtImm;
    assign muxAin          = ctrl_q.muxAin;
    assign muxToRegFile    = ctrl_q.muxToRegFile;
    assign muxShiftAmount  = ctrl_q.muxShiftAmount;
    assign muxShiftShifter = ctrl_q.muxShiftShifter;
    assign muxOut          = ctrl_q.muxOut;
    assign pcEn            = ctrl_q.pcEn;
    assign aluOp           = ctrl_q.aluOp;
    assign state           = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction table with state traces and enable counts,
// plus a small PC/register model to check jump, link and branch targets.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opCode, opCodeExt;
    logic       condTrue = 1'b0;
    logic       instrRegEn, regFileEn, memDataRegEn, muxMemAdr, outRegEn, codesComputed;
    logic       muxBin, muxPc, shiftOp, memWrite;
    logic [1:0] muxExtImm, muxAin, muxToRegFile, muxShiftAmount, muxShiftShifter, muxOut, pcEn;
    logic [4:0] aluOp;
    logic [3:0] state;

    multicycle_controller #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .opCode(opCode), .opCodeExt(opCodeExt), .condTrue(condTrue),
        .instrRegEn(instrRegEn), .regFileEn(regFileEn), .memDataRegEn(memDataRegEn),
        .muxMemAdr(muxMemAdr), .outRegEn(outRegEn), .codesComputed(codesComputed),
        .muxBin(muxBin), .muxPc(muxPc), .shiftOp(shiftOp), .muxExtImm(muxExtImm),
        .muxAin(muxAin), .muxToRegFile(muxToRegFile), .muxShiftAmount(muxShiftAmount),
        .muxShiftShifter(muxShiftShifter), .muxOut(muxOut), .pcEn(pcEn), .aluOp(aluOp),
        .memWrite(memWrite), .state(state)
    );

    always #5 clk = ~clk;

    // Minimal datapath stand-in: IR, PC, output register and register file
    logic [15:0] mem_instr = 16'h0000, pc_init = 16'h0000, r7_init = 16'h0000;
    logic [15:0] ir, pc, outr, a_val, b_val;
    logic [15:0] rf [16];

    assign opCode    = ir[15:12];
    assign opCodeExt = ir[7:4];

    always_comb begin
        case (muxAin)
            2'b00:   a_val = pc;
            2'b01:   a_val = rf[ir[11:8]];
            default: a_val = 16'h0000;
        endcase
        b_val = muxBin ? {{8{ir[7]}}, ir[7:0]} : rf[ir[3:0]];
    end

    always @(posedge clk) begin
        if (reset) begin
            ir <= 16'h0000;
            pc <= pc_init;
            outr <= 16'h0000;
            for (int i = 0; i < 16; i++) rf[i] <= 16'h0000;
            rf[7] <= r7_init;
        end else begin
            if (instrRegEn) ir <= mem_instr;
            if (pcEn == 2'b11 && !muxPc) pc <= pc + 16'd1;
            else if (pcEn == 2'b10 && muxPc) pc <= outr;
            if (outRegEn) outr <= a_val + b_val;
            if (regFileEn && muxToRegFile == 2'b10) rf[ir[11:8]] <= pc;
        end
    end

    typedef struct {
        logic [15:0] instr;
        logic        cond;
        int          len;
        logic [31:0] seq;
        int          rf, mw, mdr, pcj, pci;
        logic        ex;
        logic [4:0]  alu;
        logic        mb;
        logic [1:0]  eimm;
        logic        cc;
        logic [1:0]  mo, sa, ss;
        logic        so;
    } vec_t;

    vec_t tbl [20];
    int   tests = 0, errors = 0;

    int          r_len, r_rf, r_mw, r_mdr, r_pcj, r_pci;
    logic [31:0] r_seq;
    logic [18:0] r_ex;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered at a negedge with state==FETCH; returns at the next FETCH
    task automatic run(input logic [15:0] instr, input logic cond);
        mem_instr = instr;
        condTrue  = cond;
        r_len = 0; r_seq = '0; r_ex = '0;
        r_rf = 0; r_mw = 0; r_mdr = 0; r_pcj = 0; r_pci = 0;
        do begin
            r_seq = {r_seq[27:0], state};
            r_len++;
            if (regFileEn)     r_rf++;
            if (memWrite)      r_mw++;
            if (memDataRegEn)  r_mdr++;
            if (pcEn == 2'b10) r_pcj++;
            if (pcEn == 2'b11) r_pci++;
            if (state == 4'd3)
                r_ex = {aluOp, muxBin, muxExtImm, codesComputed, muxOut, muxShiftAmount,
                        muxShiftShifter, shiftOp, muxAin, outRegEn};
            @(negedge clk);
        end while (state != 4'd0 && r_len < 12);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        //          instr     c  len seq           rf mw md pj pi ex alu mb eimm cc mo sa ss so
        tbl[0]  = '{16'h0353, 0, 5, 32'h01234,    1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0}; // ADD
        tbl[1]  = '{16'h1280, 0, 5, 32'h01234,    1, 0, 0, 0, 1, 1, 2, 1, 2, 0, 1, 0, 0, 0}; // ANDI
        tbl[2]  = '{16'hB201, 0, 4, 32'h0123,     0, 0, 0, 0, 1, 1, 5, 1, 0, 1, 1, 0, 0, 0}; // CMPI
        tbl[3]  = '{16'h0192, 0, 5, 32'h01234,    1, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0}; // SUB
        tbl[4]  = '{16'h01D2, 0, 5, 32'h01234,    1, 0, 0, 0, 1, 1, 6, 0, 0, 0, 1, 0, 0, 0}; // MOV
        tbl[5]  = '{16'h3105, 0, 5, 32'h01234,    1, 0, 0, 0, 1, 1, 4, 1, 2, 0, 1, 0, 0, 0}; // XORI
        tbl[6]  = '{16'h5307, 0, 5, 32'h01234,    1, 0, 0, 0, 1, 1, 0, 1, 0, 1, 1, 0, 0, 0}; // ADDI
        tbl[7]  = '{16'h8101, 0, 5, 32'h01234,    1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0}; // LSHI
        tbl[8]  = '{16'h8162, 0, 5, 32'h01234,    1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1}; // ASHU
        tbl[9]  = '{16'h8133, 0, 5, 32'h01234,    1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 1}; // ASHUI
        tbl[10] = '{16'hF112, 0, 5, 32'h01234,    1, 0, 0, 0, 1, 1, 0, 0, 2, 0, 0, 2, 1, 0}; // LUI
        tbl[11] = '{16'h4104, 0, 6, 32'h012567,   1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0}; // LOAD
        tbl[12] = '{16'h4146, 0, 4, 32'h0128,     0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0}; // STOR
        tbl[13] = '{16'hC0FE, 1, 6, 32'h012DEB,   0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0}; // BEQ taken
        tbl[14] = '{16'hC0FE, 0, 4, 32'h012D,     0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0}; // BEQ not
        tbl[15] = '{16'h41C3, 1, 6, 32'h0129AB,   0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0}; // Jcond taken
        tbl[16] = '{16'h41C3, 0, 4, 32'h0129,     0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0}; // Jcond not
        tbl[17] = '{16'h4787, 0, 7, 32'h0129ACB,  1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0}; // JAL
        tbl[18] = '{16'h6123, 0, 3, 32'h012,      0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0}; // NOP opcode
        tbl[19] = '{16'h0103, 0, 3, 32'h012,      0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0}; // bad R ext

        do_reset(2);
        chk("reset state", state, 4'd0);
        chk("reset outputs",
            {instrRegEn, regFileEn, memDataRegEn, muxMemAdr, outRegEn, codesComputed, muxBin, muxPc,
             shiftOp, memWrite, muxExtImm, muxAin, muxToRegFile, muxShiftAmount, muxShiftShifter,
             muxOut, pcEn, aluOp}, '0);

        for (int i = 0; i < 20; i++) begin
            run(tbl[i].instr, tbl[i].cond);
            chk($sformatf("v%0d len", i), r_len, tbl[i].len);
            chk($sformatf("v%0d states", i), r_seq, tbl[i].seq);
            chk($sformatf("v%0d regFileEn cycles", i), r_rf, tbl[i].rf);
            chk($sformatf("v%0d memWrite cycles", i), r_mw, tbl[i].mw);
            chk($sformatf("v%0d memDataRegEn cycles", i), r_mdr, tbl[i].mdr);
            chk($sformatf("v%0d pcEn=10 cycles", i), r_pcj, tbl[i].pcj);
            chk($sformatf("v%0d pcEn=11 cycles", i), r_pci, tbl[i].pci);
            if (tbl[i].ex)
                chk($sformatf("v%0d ALU_EX ctrl", i), r_ex,
                    {tbl[i].alu, tbl[i].mb, tbl[i].eimm, tbl[i].cc, tbl[i].mo, tbl[i].sa,
                     tbl[i].ss, tbl[i].so, 2'b01, 1'b1});
        end

        // Reset held 3 cycles while a LOAD sits in LD_CAP
        begin
            int n;
            mem_instr = 16'h4104;
            n = 0;
            while (state != 4'd6 && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("reach LD_CAP", state, 4'd6);
            chk("LD_CAP memDataRegEn", memDataRegEn, 1'b1);
            reset = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                chk($sformatf("reset c%0d state", c), state, 4'd0);
                chk($sformatf("reset c%0d enables", c), {regFileEn, memWrite, pcEn}, 4'b0000);
            end
            reset = 1'b0;
            @(negedge clk);
            chk("post-reset LATCH", state, 4'd1);
            n = 0;
            while (state != 4'd0 && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("post-reset back to FETCH", state, 4'd0);
        end

        // JAL R7,R7: target is the old R7, link is the return address
        pc_init = 16'h0020; r7_init = 16'h0100;
        do_reset(2);
        run(16'h4787, 1'b0);
        chk("JAL len", r_len, 7);
        chk("JAL pc", pc, 16'h0100);
        chk("JAL link R7", rf[7], 16'h0021);

        // BEQ disp=-2 at 0x30 lands at 0x30 + 1 - 2
        pc_init = 16'h0030;
        do_reset(2);
        run(16'hC0FE, 1'b1);
        chk("BEQ target", pc, 16'h002F);

        pc_init = 16'h0030;
        do_reset(2);
        run(16'hC0FE, 1'b0);
        chk("BEQ not-taken pc", pc, 16'h0031);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
